// File: rtl/decode_stage.sv
// decode_stage
//   Instruction decode for the MIPS-I integer subset, sitting directly behind
//   fetch. Each accepted instruction is decoded combinationally and captured
//   into a two-entry skid buffer (output register + one skid slot), so the
//   upstream ready is a flop and never depends on downstream ready.
//
// Ports
//   clk, reset            : clock (rising edge), async active-low reset
//   flush                 : drop everything held and anything arriving this cycle
//   if_valid / if_ready   : fetch handshake (if_ready is registered)
//   if_instruction, if_pc : instruction word (big-endian corrected) and its PC
//   id_valid / id_ready   : execute handshake
//   id_pc, id_rs, id_rt, id_rd, id_imm, id_shamt, id_alu_op : decoded fields
//   id_alu_src_imm .. id_illegal : control flags
//   id_target             : branch/jump target, 0 for everything else
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instruction,
    input  logic [31:0] if_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [31:0] id_imm,
    output logic [4:0]  id_shamt,
    output logic [3:0]  id_alu_op,
    output logic        id_alu_src_imm,
    output logic        id_reg_write,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_branch_eq,
    output logic        id_branch_ne,
    output logic        id_jump,
    output logic        id_jump_reg,
    output logic        id_illegal,
    output logic [31:0] id_target
);

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                           ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_NOR = 4'd5,
                           ALU_SLT = 4'd6, ALU_SLTU = 4'd7, ALU_SLL = 4'd8,
                           ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [3:0]  alu_op;
        logic        alu_src_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch_eq;
        logic        branch_ne;
        logic        jump;
        logic        jump_reg;
        logic        illegal;
        logic [31:0] target;
    } bundle_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    function automatic bundle_t decode(input logic [31:0] ins, input logic [31:0] pc);
        bundle_t     b;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] sext;
        logic [31:0] pc4;
        logic [4:0]  dst;
        logic        wr;
        b    = '0;
        op   = ins[31:26];
        fn   = ins[5:0];
        sext = {{16{ins[15]}}, ins[15:0]};
        pc4  = pc + 32'd4;
        dst  = 5'd0;
        wr   = 1'b0;

        b.pc    = pc;
        b.rs    = ins[25:21];
        b.rt    = ins[20:16];
        b.shamt = ins[10:6];
        // Logical immediates are zero-extended, everything else sign-extended
        b.imm   = (op == 6'h0C || op == 6'h0D || op == 6'h0E) ? {16'h0, ins[15:0]} : sext;

        case (op)
            6'h00: begin
                dst = ins[15:11];
                wr  = 1'b1;
                case (fn)
                    6'h20, 6'h21: b.alu_op = ALU_ADD;
                    6'h22, 6'h23: b.alu_op = ALU_SUB;
                    6'h24:        b.alu_op = ALU_AND;
                    6'h25:        b.alu_op = ALU_OR;
                    6'h26:        b.alu_op = ALU_XOR;
                    6'h27:        b.alu_op = ALU_NOR;
                    6'h2A:        b.alu_op = ALU_SLT;
                    6'h2B:        b.alu_op = ALU_SLTU;
                    6'h00:        b.alu_op = ALU_SLL;
                    6'h02:        b.alu_op = ALU_SRL;
                    6'h03:        b.alu_op = ALU_SRA;
                    6'h08: begin
                        b.jump_reg = 1'b1;
                        wr         = 1'b0;
                    end
                    default: begin
                        b.illegal = 1'b1;
                        wr        = 1'b0;
                    end
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                dst = ins[20:16];
                wr  = 1'b1;
                b.alu_src_imm = 1'b1;
                case (op)
                    6'h0A:   b.alu_op = ALU_SLT;
                    6'h0B:   b.alu_op = ALU_SLTU;
                    6'h0C:   b.alu_op = ALU_AND;
                    6'h0D:   b.alu_op = ALU_OR;
                    6'h0E:   b.alu_op = ALU_XOR;
                    6'h0F:   b.alu_op = ALU_LUI;
                    default: b.alu_op = ALU_ADD;
                endcase
            end
            6'h23: begin
                dst = ins[20:16];
                wr  = 1'b1;
                b.alu_src_imm = 1'b1;
                b.mem_read    = 1'b1;
            end
            6'h2B: begin
                dst = ins[20:16];
                b.alu_src_imm = 1'b1;
                b.mem_write   = 1'b1;
            end
            6'h04, 6'h05: begin
                dst         = ins[20:16];
                b.alu_op    = ALU_SUB;
                b.branch_eq = (op == 6'h04);
                b.branch_ne = (op == 6'h05);
                b.target    = pc4 + {sext[29:0], 2'b00};
            end
            6'h02, 6'h03: begin
                b.jump   = 1'b1;
                b.target = {pc4[31:28], ins[25:0], 2'b00};
                if (op == 6'h03) begin
                    dst = 5'd31;
                    wr  = 1'b1;
                end
            end
            default: b.illegal = 1'b1;
        endcase

        b.rd        = b.illegal ? 5'd0 : dst;
        // Writes to $zero are suppressed but rd still reports the destination
        b.reg_write = wr && (dst != 5'd0);
        return b;
    endfunction

    bundle_t dec;
    assign dec = decode(if_instruction, if_pc);

    // ------------------------------------------------------------------
    // Skid buffer control
    // ------------------------------------------------------------------
    state_e  state_q, state_d;
    logic    rdy_q, vld_q;
    bundle_t out_q, skid_q;
    logic    acc, drn;
    logic    ld_out, ld_skid, sel_skid;

    assign acc = if_valid && rdy_q;
    assign drn = vld_q && id_ready;

    // State register; ready/valid are flopped from the next state so neither
    // output has a combinational path from the handshake inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != TWO);
            vld_q   <= (state_d != EMPTY);
        end
    end

    // Next-state logic; flush overrides both accept and drain
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (acc) state_d = ONE;
                ONE: begin
                    if (acc && !drn)      state_d = TWO;
                    else if (!acc && drn) state_d = EMPTY;
                end
                TWO:     if (drn) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Datapath load controls
    always_comb begin
        ld_out   = 1'b0;
        ld_skid  = 1'b0;
        sel_skid = 1'b0;
        if (!flush) begin
            case (state_q)
                EMPTY: ld_out = acc;
                ONE: begin
                    ld_out  = acc && drn;
                    ld_skid = acc && !drn;
                end
                TWO: begin
                    ld_out   = drn;
                    sel_skid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (ld_out)  out_q  <= sel_skid ? skid_q : dec;
            if (ld_skid) skid_q <= dec;
        end
    end

    assign if_ready       = rdy_q;
    assign id_valid       = vld_q;
    assign id_pc          = out_q.pc;
    assign id_rs          = out_q.rs;
    assign id_rt          = out_q.rt;
    assign id_rd          = out_q.rd;
    assign id_imm         = out_q.imm;
    assign id_shamt       = out_q.shamt;
    assign id_alu_op      = out_q.alu_op;
    assign id_alu_src_imm = out_q.alu_src_imm;
    assign id_reg_write   = out_q.reg_write;
    assign id_mem_read    = out_q.mem_read;
    assign id_mem_write   = out_q.mem_write;
    assign id_branch_eq   = out_q.branch_eq;
    assign id_branch_ne   = out_q.branch_ne;
    assign id_jump        = out_q.jump;
    assign id_jump_reg    = out_q.jump_reg;
    assign id_illegal     = out_q.illegal;
    assign id_target      = out_q.target;

endmodule
